dcache_wt: RTL and testbench

Parametrised direct-mapped, write-through, no-write-allocate data cache between the core's load/store unit and the data-memory port. It is the successor of the fixed-geometry data cache, with configurable line count, multi-word lines with burst refill, byte-strobed writes and a bulk invalidate. Processor and memory sides both use level request / one-cycle response handshakes.

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_data_ram.sv | 26 ++
 rtl/dcache_wt.sv | 188 ++++++++++++++++++
 tb/tb_dcache_wt.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        REFILL,
        WRITE
    } state_t;

    // Geometry is derived from the module parameters at elaboration time.
    function automatic int offset_bits(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int addr_width, input int lines, input int words_per_line);
        return addr_width - offset_bits(words_per_line) - index_bits(lines);
    endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Single-port data array: synchronous read, per-byte write enables.
module dcache_data_ram #(
    parameter int DEPTH      = 128,
    parameter int ADDR_BITS  = 7
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [3:0]           byte_enable,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data
);

    logic [31:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; the valid bits alone decide
    // whether a word is meaningful, so clearing data would only cost logic.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (byte_enable[b]) begin
                mem[addr][8*b +: 8] <= write_data[8*b +: 8];
            end
        end
        read_data <= mem[addr];
    end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with burst refill.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int LINES          = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_request,
    input  logic                  write_request,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           write_data,
    input  logic [3:0]            write_strobe,
    input  logic                  invalidate,
    output logic                  response,
    output logic [31:0]           read_data,
    output logic                  memory_read_request,
    output logic                  memory_write_request,
    output logic [ADDR_WIDTH-1:0] memory_addr,
    output logic [31:0]           memory_write_data,
    output logic [3:0]            memory_write_strobe,
    input  logic                  memory_response,
    input  logic [31:0]           memory_read_data
);

    localparam int OFFSET_BITS = offset_bits(WORDS_PER_LINE);
    localparam int WORD_BITS   = OFFSET_BITS - 2;
    localparam int INDEX_BITS  = index_bits(LINES);
    localparam int TAG_BITS    = tag_bits(ADDR_WIDTH, LINES, WORDS_PER_LINE);
    localparam int RAM_BITS    = INDEX_BITS + WORD_BITS;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [31:0]             req_data;
    logic [3:0]              req_strobe;
    logic [WORD_BITS-1:0]    beat;
    logic [LINES-1:0]        valid;
    logic [TAG_BITS-1:0]     tags [LINES];
    logic [31:0]             fill_data;
    logic                    fill_bypass;

    logic [INDEX_BITS-1:0]   req_index;
    logic [TAG_BITS-1:0]     req_tag;
    logic [WORD_BITS-1:0]    req_word;
    logic [INDEX_BITS-1:0]   addr_index;
    logic [WORD_BITS-1:0]    addr_word;
    logic                    hit;
    logic                    last_beat;
    logic                    fill_done;

    logic [RAM_BITS-1:0]     ram_addr;
    logic [3:0]              ram_be;
    logic [31:0]             ram_wdata;
    logic [31:0]             ram_rdata;

    assign req_index  = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_tag    = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_word   = req_addr[2 +: WORD_BITS];
    assign addr_index = addr[OFFSET_BITS +: INDEX_BITS];
    assign addr_word  = addr[2 +: WORD_BITS];
    assign hit        = valid[req_index] && (tags[req_index] == req_tag);
    assign last_beat  = &beat;
    assign fill_done  = (state == REFILL) && memory_response && last_beat;

    // The single RAM port is shared: IDLE reads ahead from the live address so
    // a hit answers in COMPARE; refill beats and write-hit merges take it over.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ram_addr  = {req_index, req_word};
        ram_be    = 4'h0;
        ram_wdata = memory_read_data;
        unique case (state)
            IDLE: ram_addr = {addr_index, addr_word};
            REFILL: begin
                if (memory_response) begin
                    ram_addr = {req_index, beat};
                    ram_be   = 4'hF;
                end
            end
            WRITE: begin
                if (memory_response && hit) begin
                    ram_be    = req_strobe;
                    ram_wdata = req_data;
                end
            end
            default: ;
        endcase
    end

    dcache_data_ram #(
        .DEPTH     (LINES * WORDS_PER_LINE),
        .ADDR_BITS (RAM_BITS)
    ) u_data_ram (
        .clk         (clk),
        .addr        (ram_addr),
        .byte_enable (ram_be),
        .write_data  (ram_wdata),
        .read_data   (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            valid       <= '0;
            beat        <= '0;
            fill_bypass <= 1'b0;
            req_addr    <= '0;
            req_data    <= '0;
            req_strobe  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    fill_bypass <= 1'b0;
                    if (invalidate) begin
                        valid <= '0;
                    end else if (write_request) begin
                        req_addr   <= addr;
                        req_data   <= write_data;
                        req_strobe <= write_strobe;
                        state      <= WRITE;
                    end else if (read_request) begin
                        req_addr <= addr;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        state <= IDLE;
                    end else begin
                        valid[req_index] <= 1'b0;
                        beat             <= '0;
                        state            <= REFILL;
                    end
                end
                REFILL: begin
                    if (memory_response) begin
                        // The port is busy writing the last beat, so the
                        // requested word is kept aside for the following COMPARE.
                        if (beat == req_word) begin
                            fill_data <= memory_read_data;
                        end
                        beat <= beat + WORD_BITS'(1);
                        if (last_beat) begin
                            valid[req_index] <= 1'b1;
                            fill_bypass      <= 1'b1;
                            state            <= COMPARE;
                        end
                    end
                end
                WRITE: begin
                    if (memory_response) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tags[req_index] <= req_tag;
        end
    end

    always_comb begin
        response             = ((state == COMPARE) && hit) || ((state == WRITE) && memory_response);
        read_data            = ((state == COMPARE) && hit) ? (fill_bypass ? fill_data : ram_rdata) : 32'h0;
        memory_read_request  = (state == REFILL);
        memory_write_request = (state == WRITE);
        memory_addr          = '0;
        memory_write_data    = 32'h0;
        memory_write_strobe  = 4'h0;
        if (state == REFILL) begin
            memory_addr = {req_addr[ADDR_WIDTH-1:OFFSET_BITS], beat, 2'b00};
        end else if (state == WRITE) begin
            memory_addr         = req_addr & ~ADDR_WIDTH'(3);
            memory_write_data   = req_data;
            memory_write_strobe = req_strobe;
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt against a memory image and a tag/valid model.
module tb_dcache_wt;

    localparam int LINES = 32;
    localparam int WPL   = 4;
    localparam int OFF   = 4;
    localparam int IDXB  = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_request, write_request, invalidate;
    logic [31:0] addr, write_data;
    logic [3:0]  write_strobe;
    logic        response;
    logic [31:0] read_data;
    logic        memory_read_request, memory_write_request;
    logic [31:0] memory_addr, memory_write_data;
    logic [3:0]  memory_write_strobe;
    logic        memory_response;
    logic [31:0] memory_read_data;

    always #5 clk = ~clk;

    dcache_wt #(.LINES(LINES), .WORDS_PER_LINE(WPL), .ADDR_WIDTH(32)) dut (
        .clk                  (clk),
        .reset                (reset),
        .read_request         (read_request),
        .write_request        (write_request),
        .addr                 (addr),
        .write_data           (write_data),
        .write_strobe         (write_strobe),
        .invalidate           (invalidate),
        .response             (response),
        .read_data            (read_data),
        .memory_read_request  (memory_read_request),
        .memory_write_request (memory_write_request),
        .memory_addr          (memory_addr),
        .memory_write_data    (memory_write_data),
        .memory_write_strobe  (memory_write_strobe),
        .memory_response      (memory_response),
        .memory_read_data     (memory_read_data)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Memory side: fixed per-word latency, traffic log.
    int          mem_latency = 2;
    int          mem_cnt;
    logic [31:0] mem [bit [31:0]];
    logic [31:0] ref_mem [bit [31:0]];
    int          rd_count, wr_count;
    logic [31:0] rd_addrs [$];
    logic [31:0] last_wr_addr, last_wr_data;
    logic [3:0]  last_wr_strobe;

    // Reference cache state.
    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];
    int          e_lat, e_rd, e_wr;
    logic [31:0] e_data;

    // Observations from the last access.
    logic [31:0] obs_data;
    int          obs_lat;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a ^ 32'hC0DE_0000) * 32'h0001_0003 + 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    initial begin
        memory_response  = 1'b0;
        memory_read_data = 32'h0;
        mem_cnt          = 0;
        forever begin
            @(negedge clk);
            memory_response  = 1'b0;
            memory_read_data = 32'h0;
            if (memory_read_request || memory_write_request) begin
                mem_cnt++;
                if (mem_cnt >= mem_latency) begin
                    mem_cnt         = 0;
                    memory_response = 1'b1;
                    if (memory_read_request) begin
                        memory_read_data = mem.exists(memory_addr) ? mem[memory_addr] : init_word(memory_addr);
                        rd_count++;
                        rd_addrs.push_back(memory_addr);
                    end else begin
                        logic [31:0] w;
                        w = mem.exists(memory_addr) ? mem[memory_addr] : init_word(memory_addr);
                        for (int b = 0; b < 4; b++)
                            if (memory_write_strobe[b]) w[8*b +: 8] = memory_write_data[8*b +: 8];
                        mem[memory_addr] = w;
                        wr_count++;
                        last_wr_addr   = memory_addr;
                        last_wr_data   = memory_write_data;
                        last_wr_strobe = memory_write_strobe;
                    end
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    // Expected behaviour from the cache rules; also advances the model.
    task automatic predict(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        int          idx;
        logic [31:0] tg, wa, v;
        bit          hit;
        idx = int'((a >> OFF) % LINES);
        tg  = a >> (OFF + IDXB);
        wa  = {a[31:2], 2'b00};
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (w) begin
            e_lat = mem_latency; e_rd = 0; e_wr = 1;
            v = ref_word(wa);
            for (int b = 0; b < 4; b++) if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
            ref_mem[wa] = v;
            e_data = 32'h0;
        end else begin
            e_wr   = 0;
            e_rd   = hit ? 0 : WPL;
            e_lat  = hit ? 1 : 2 + WPL * mem_latency;
            e_data = ref_word(wa);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
    endtask

    task automatic do_access(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        predict(w, a, wd, st);
        rd_addrs.delete();
        rd_count = 0;
        wr_count = 0;
        obs_lat  = -1;
        obs_data = 32'hx;
        @(posedge clk); #1;
        addr = a; write_data = wd; write_strobe = st;
        read_request = !w; write_request = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (response) begin
                obs_data = read_data;
                obs_lat  = i;
                break;
            end
        end
        @(posedge clk); #1;
        read_request = 1'b0; write_request = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks_total++;
        if ({response, read_data, memory_read_request, memory_write_request, memory_addr,
             memory_write_data, memory_write_strobe} !== '0)
            $display("FAIL reset_outputs: got resp=%b rd=%h mrr=%b mwr=%b ma=%h mwd=%h mws=%h required all zero",
                     response, read_data, memory_read_request, memory_write_request, memory_addr,
                     memory_write_data, memory_write_strobe);
        else checks_passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_cold_read();
        bit ok;
        mem_latency = 2;
        do_access(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        checks_total++;
        if (obs_lat !== 10) $display("FAIL cold_latency: got %0d required 10", obs_lat);
        else checks_passed++;
        ok = (rd_addrs.size() == WPL);
        for (int i = 0; i < WPL && ok; i++) if (rd_addrs[i] !== 32'h10 + 32'(4 * i)) ok = 1'b0;
        checks_total++;
        if (!ok) $display("FAIL cold_beats: got %0d reads (first %h) required 4 reads 10,14,18,1c",
                          rd_count, rd_addrs.size() > 0 ? rd_addrs[0] : 32'hx);
        else checks_passed++;
        checks_total++;
        if (obs_data !== e_data) $display("FAIL cold_data: got %h required %h", obs_data, e_data);
        else checks_passed++;
        do_access(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        checks_total++;
        if (obs_lat !== 1 || rd_count !== 0)
            $display("FAIL repeat_hit: got latency %0d reads %0d required 1 and 0", obs_lat, rd_count);
        else checks_passed++;
        checks_total++;
        if (obs_data !== e_data) $display("FAIL repeat_data: got %h required %h", obs_data, e_data);
        else checks_passed++;
    endtask

    task automatic test_conflict();
        logic [31:0] seq [3] = '{32'h0, 32'h200, 32'h0};
        for (int i = 0; i < 3; i++) begin
            do_access(1'b0, seq[i], 32'h0, 4'h0);
            checks_total++;
            if (rd_count !== WPL || e_rd !== WPL || obs_data !== e_data)
                $display("FAIL conflict_%0d: got reads %0d data %h required reads 4 data %h",
                         i, rd_count, obs_data, e_data);
            else checks_passed++;
        end
    endtask

    task automatic test_strobe_write();
        do_access(1'b0, 32'h4, 32'h0, 4'h0);
        checks_total++;
        if (obs_data !== 32'h1122_3344) $display("FAIL strobe_preload: got %h required 11223344", obs_data);
        else checks_passed++;
        do_access(1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101);
        checks_total++;
        if (wr_count !== 1 || last_wr_strobe !== 4'b0101 || last_wr_addr !== 32'h4 || obs_lat !== mem_latency)
            $display("FAIL strobe_mem_write: got writes %0d strobe %b addr %h latency %0d required 1 0101 4 %0d",
                     wr_count, last_wr_strobe, last_wr_addr, obs_lat, mem_latency);
        else checks_passed++;
        do_access(1'b0, 32'h4, 32'h0, 4'h0);
        checks_total++;
        if (obs_data !== 32'h11BB_33DD || obs_lat !== 1 || rd_count !== 0)
            $display("FAIL strobe_merge: got %h latency %0d reads %0d required 11bb33dd 1 0",
                     obs_data, obs_lat, rd_count);
        else checks_passed++;
    endtask

    task automatic test_uncached_write();
        do_access(1'b1, 32'h400, 32'hDEAD_BEEF, 4'hF);
        checks_total++;
        if (wr_count !== 1 || rd_count !== 0)
            $display("FAIL uncached_write: got writes %0d reads %0d required 1 0", wr_count, rd_count);
        else checks_passed++;
        do_access(1'b0, 32'h400, 32'h0, 4'h0);
        checks_total++;
        if (rd_count !== WPL || obs_data !== 32'hDEAD_BEEF)
            $display("FAIL uncached_read: got reads %0d data %h required 4 deadbeef", rd_count, obs_data);
        else checks_passed++;
    endtask

    task automatic test_invalidate();
        do_access(1'b0, 32'h40, 32'h0, 4'h0);
        do_access(1'b0, 32'h80, 32'h0, 4'h0);
        @(posedge clk); #1 invalidate = 1'b1;
        @(posedge clk); #1 invalidate = 1'b0;
        model_clear();
        do_access(1'b0, 32'h40, 32'h0, 4'h0);
        checks_total++;
        if (rd_count !== WPL) $display("FAIL invalidate_a: got reads %0d required 4", rd_count);
        else checks_passed++;
        do_access(1'b0, 32'h80, 32'h0, 4'h0);
        checks_total++;
        if (rd_count !== WPL || obs_data !== e_data)
            $display("FAIL invalidate_b: got reads %0d data %h required 4 %h", rd_count, obs_data, e_data);
        else checks_passed++;
    endtask

    task automatic test_reset_mid_refill();
        bit seen = 1'b0;
        mem_latency = 2;
        @(posedge clk); #1;
        addr = 32'h100; read_request = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk); #1;
            if (memory_read_request && memory_addr === 32'h108) seen = 1'b1;
        end
        checks_total++;
        if (!seen) $display("FAIL midrefill_reach: got no beat-2 address required 108");
        else checks_passed++;
        reset = 1'b0;
        @(negedge clk); #1;
        checks_total++;
        if ({response, read_data, memory_read_request, memory_write_request, memory_addr,
             memory_write_data, memory_write_strobe} !== '0)
            $display("FAIL midrefill_reset: got resp=%b mrr=%b ma=%h required all zero",
                     response, memory_read_request, memory_addr);
        else checks_passed++;
        reset = 1'b1; read_request = 1'b0;
        model_clear();
        do_access(1'b0, 32'h100, 32'h0, 4'h0);
        checks_total++;
        if (rd_count !== WPL || rd_addrs.size() == 0 || rd_addrs[0] !== 32'h100 || obs_data !== e_data)
            $display("FAIL midrefill_reread: got reads %0d data %h required 4 from 100 data %h",
                     rd_count, obs_data, e_data);
        else checks_passed++;
    endtask

    task automatic test_random();
        logic [31:0] a, wd;
        logic [3:0]  st;
        bit          w;
        for (int n = 0; n < 80; n++) begin
            mem_latency = $urandom_range(1, 3);
            if ($urandom_range(0, 14) == 0) begin
                @(posedge clk); #1 invalidate = 1'b1;
                @(posedge clk); #1 invalidate = 1'b0;
                model_clear();
            end
            a  = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 4) |
                 (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            wd = $urandom;
            st = 4'($urandom_range(1, 15));
            w  = ($urandom_range(0, 2) == 0);
            do_access(w, a, wd, st);
            checks_total++;
            if (obs_lat !== e_lat || rd_count !== e_rd || wr_count !== e_wr)
                $display("FAIL random_%0d_traffic: addr %h write %0d got lat %0d rd %0d wr %0d required %0d %0d %0d",
                         n, a, w, obs_lat, rd_count, wr_count, e_lat, e_rd, e_wr);
            else checks_passed++;
            checks_total++;
            if (w ? ({last_wr_addr, last_wr_data, last_wr_strobe} !== {a & ~32'h3, wd, st})
                  : (obs_data !== e_data))
                $display("FAIL random_%0d_data: addr %h write %0d got %h/%h/%b required %h/%h/%b",
                         n, a, w, w ? last_wr_data : obs_data, last_wr_addr, last_wr_strobe,
                         w ? wd : e_data, a & ~32'h3, st);
            else checks_passed++;
        end
    endtask

    initial begin
        reset = 1'b0; read_request = 1'b0; write_request = 1'b0; invalidate = 1'b0;
        addr = 32'h0; write_data = 32'h0; write_strobe = 4'h0;
        mem[32'h4]     = 32'h1122_3344;
        ref_mem[32'h4] = 32'h1122_3344;
        test_reset();
        test_cold_read();
        test_conflict();
        test_strobe_write();
        test_uncached_write();
        test_invalidate();
        test_reset_mid_refill();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
